// File: rtl/nios_ram_dp.sv
// rtl/nios_ram_dp.sv - dual-port RAM: Avalon-MM CPU port, read-only streaming port, power-up zero fill
module nios_ram_dp #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 11,
   parameter int OUTREG         = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [ADDR_WIDTH-1:0]   s1_address,
   input  logic                    s1_chipselect,
   input  logic                    s1_read,
   input  logic                    s1_write,
   input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
   input  logic [DATA_WIDTH-1:0]   s1_writedata,
   output logic [DATA_WIDTH-1:0]   s1_readdata,
   output logic                    s1_readdatavalid,
   output logic                    s1_waitrequest,
   input  logic [ADDR_WIDTH-1:0]   s2_address,
   input  logic                    s2_read,
   output logic [DATA_WIDTH-1:0]   s2_readdata,
   output logic                    s2_readdatavalid,
   output logic                    s2_waitrequest,
   output logic                    init_done
);
   localparam int DEPTH  = 1 << ADDR_WIDTH;
   localparam int NBYTES = DATA_WIDTH / 8;

   typedef enum logic {CLEAR, READY} state_t;
   localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

   state_t                  state, state_next;
   logic [ADDR_WIDTH-1:0]   clr_addr, clr_addr_next;
   logic                    clr_we;
   logic                    busy;
   logic                    s1_wr, s1_rd, s2_rd;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [DATA_WIDTH-1:0]   wr_merge;
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_waddr;
   logic [DATA_WIDTH-1:0]   mem_wdata;

   logic [DATA_WIDTH-1:0]   s1_q, s2_q;
   logic                    s1_v, s2_v;

   // Controller state and clear counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= RESET_STATE;
         clr_addr <= '0;
      end else begin
         state    <= state_next;
         clr_addr <= clr_addr_next;
      end
   end

   always_comb begin
      state_next    = state;
      clr_addr_next = clr_addr;
      clr_we        = 1'b0;
      case (state)
         CLEAR: begin
            clr_we        = reset_n;
            clr_addr_next = clr_addr + 1'b1;
            if (&clr_addr)
               state_next = READY;
         end
         READY: begin
            state_next = READY;
         end
      endcase
   end

   // Reset is folded in so waitrequest reads 1 during reset even when no clear pass follows
   assign busy           = (state != READY) || !reset_n;
   assign s1_waitrequest = busy;
   assign s2_waitrequest = busy;
   assign init_done      = ~busy;

   assign s1_wr = s1_chipselect & s1_write & ~busy;
   assign s1_rd = s1_chipselect & s1_read & ~s1_write & ~busy;
   assign s2_rd = s2_read & ~busy;

   // Byte-lane merge of the current word with the enabled write lanes
   always_comb begin
      wr_merge = mem[s1_address];
      for (int i = 0; i < NBYTES; i++) begin
         if (s1_byteenable[i])
            wr_merge[8*i +: 8] = s1_writedata[8*i +: 8];
      end
   end

   assign mem_we    = clr_we | s1_wr;
   assign mem_waddr = clr_we ? clr_addr : s1_address;
   assign mem_wdata = clr_we ? '0 : wr_merge;

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_waddr] <= mem_wdata;
   end

   // Read stage: non-blocking memory update gives s2 the pre-write word on a same-cycle collision
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q <= '0;
         s1_v <= 1'b0;
         s2_q <= '0;
         s2_v <= 1'b0;
      end else begin
         s1_v <= s1_rd;
         s2_v <= s2_rd;
         if (s1_rd)
            s1_q <= mem[s1_address];
         if (s2_rd)
            s2_q <= mem[s2_address];
      end
   end

   generate
      if (OUTREG != 0) begin : g_outreg
         logic [DATA_WIDTH-1:0] s1_o, s2_o;
         logic                  s1_ov, s2_ov;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               s1_o  <= '0;
               s1_ov <= 1'b0;
               s2_o  <= '0;
               s2_ov <= 1'b0;
            end else begin
               s1_ov <= s1_v;
               s2_ov <= s2_v;
               if (s1_v)
                  s1_o <= s1_q;
               if (s2_v)
                  s2_o <= s2_q;
            end
         end

         assign s1_readdata      = s1_o;
         assign s1_readdatavalid = s1_ov;
         assign s2_readdata      = s2_o;
         assign s2_readdatavalid = s2_ov;
      end else begin : g_direct
         assign s1_readdata      = s1_q;
         assign s1_readdatavalid = s1_v;
         assign s2_readdata      = s2_q;
         assign s2_readdatavalid = s2_v;
      end
   endgenerate

endmodule

// File: tb/tb_nios_ram_dp.sv
// tb/tb_nios_ram_dp.sv - directed bench: OUTREG=0/1 clearing instances plus a no-clear instance on shared inputs
module tb_nios_ram_dp;
   localparam int DW = 32;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [AW-1:0] s1_address = '0;
   logic          s1_chipselect = 1'b0;
   logic          s1_read = 1'b0;
   logic          s1_write = 1'b0;
   logic [3:0]    s1_byteenable = '0;
   logic [DW-1:0] s1_writedata = '0;
   logic [AW-1:0] s2_address = '0;
   logic          s2_read = 1'b0;

   logic [DW-1:0] a_s1_rdata, a_s2_rdata, b_s1_rdata, b_s2_rdata, c_s1_rdata, c_s2_rdata;
   logic          a_s1_rdv, a_s2_rdv, b_s1_rdv, b_s2_rdv, c_s1_rdv, c_s2_rdv;
   logic          a_s1_wait, a_s2_wait, b_s1_wait, b_s2_wait, c_s1_wait, c_s2_wait;
   logic          a_init_done, b_init_done, c_init_done;

   int            n_checks = 0;
   int            n_pass = 0;
   int            n_cyc;
   logic          bad;
   logic [31:0]   exp8 [8];

   always #5 clk = ~clk;

   nios_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTREG(0), .CLEAR_ON_RESET(1)) dut_a (
      .clk(clk), .reset_n(reset_n),
      .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
      .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
      .s1_readdata(a_s1_rdata), .s1_readdatavalid(a_s1_rdv), .s1_waitrequest(a_s1_wait),
      .s2_address(s2_address), .s2_read(s2_read),
      .s2_readdata(a_s2_rdata), .s2_readdatavalid(a_s2_rdv), .s2_waitrequest(a_s2_wait),
      .init_done(a_init_done));

   nios_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTREG(1), .CLEAR_ON_RESET(1)) dut_b (
      .clk(clk), .reset_n(reset_n),
      .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
      .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
      .s1_readdata(b_s1_rdata), .s1_readdatavalid(b_s1_rdv), .s1_waitrequest(b_s1_wait),
      .s2_address(s2_address), .s2_read(s2_read),
      .s2_readdata(b_s2_rdata), .s2_readdatavalid(b_s2_rdv), .s2_waitrequest(b_s2_wait),
      .init_done(b_init_done));

   nios_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTREG(0), .CLEAR_ON_RESET(0)) dut_c (
      .clk(clk), .reset_n(reset_n),
      .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
      .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
      .s1_readdata(c_s1_rdata), .s1_readdatavalid(c_s1_rdv), .s1_waitrequest(c_s1_wait),
      .s2_address(s2_address), .s2_read(s2_read),
      .s2_readdata(c_s2_rdata), .s2_readdatavalid(c_s2_rdv), .s2_waitrequest(c_s2_wait),
      .init_done(c_init_done));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges until init_done, flagging any lowered waitrequest or stray valid on the way
   task automatic wait_clear(output int n, output logic flag);
      n = 0;
      flag = 1'b0;
      while (a_init_done !== 1'b1 && n < 40) begin
         if (a_s1_wait !== 1'b1 || a_s2_wait !== 1'b1 || b_s1_wait !== 1'b1 || b_s2_wait !== 1'b1)
            flag = 1'b1;
         if (a_s1_rdv || a_s2_rdv || b_s1_rdv || b_s2_rdv)
            flag = 1'b1;
         tick();
         n++;
      end
   endtask

   initial begin
      exp8[0] = 32'h0; exp8[1] = 32'h0; exp8[2] = 32'h0; exp8[3] = 32'hDEADBEEF;
      exp8[4] = 32'h0; exp8[5] = 32'hAA22CC44; exp8[6] = 32'h0; exp8[7] = 32'h5;

      // Reset state
      tick(); tick();
      check("rst_a_wait1", a_s1_wait, 1);
      check("rst_a_wait2", a_s2_wait, 1);
      check("rst_a_done", a_init_done, 0);
      check("rst_c_wait1", c_s1_wait, 1);
      check("rst_c_done", c_init_done, 0);
      check("rst_rdv", {a_s1_rdv, a_s2_rdv, b_s1_rdv, b_s2_rdv}, 0);
      check("rst_rdata", {a_s1_rdata, b_s2_rdata}, 0);

      reset_n = 1'b1;
      #1;
      check("noclear_ready", {c_init_done, c_s1_wait, c_s2_wait}, 3'b100);
      wait_clear(n_cyc, bad);
      check("clear_cycles", n_cyc, 16);
      check("clear_wait_held", bad, 0);
      check("b_ready", {b_init_done, b_s2_wait}, 2'b10);

      // All addresses read back zero, streaming on s2
      s2_read = 1'b1;
      for (int i = 0; i < 16; i++) begin
         s2_address = AW'(i);
         tick();
         check($sformatf("zero_a%0d", i), {a_s2_rdv, a_s2_rdata}, {1'b1, 32'h0});
         if (i == 0) check("zero_b_lat", b_s2_rdv, 0);
         else check($sformatf("zero_b%0d", i - 1), {b_s2_rdv, b_s2_rdata}, {1'b1, 32'h0});
      end
      s2_read = 1'b0;
      tick();
      check("zero_a_end", a_s2_rdv, 0);
      check("zero_b15", {b_s2_rdv, b_s2_rdata}, {1'b1, 32'h0});
      tick();
      check("zero_b_end", b_s2_rdv, 0);

      // Byte-enable merge, read immediately after write
      s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = 4'd5;
      s1_byteenable = 4'hF; s1_writedata = 32'hAABBCCDD;
      tick();
      s1_byteenable = 4'b0101; s1_writedata = 32'h11223344;
      tick();
      s1_write = 1'b0; s1_read = 1'b1;
      tick();
      check("be_a", {a_s1_rdv, a_s1_rdata}, {1'b1, 32'hAA22CC44});
      check("be_b_early", b_s1_rdv, 0);
      s1_read = 1'b0; s1_chipselect = 1'b0;
      tick();
      check("be_a_once", a_s1_rdv, 0);
      check("be_b", {b_s1_rdv, b_s1_rdata}, {1'b1, 32'hAA22CC44});
      tick();
      check("be_b_once", b_s1_rdv, 0);
      check("hold_a", a_s1_rdata, 32'hAA22CC44);
      check("hold_b", b_s1_rdata, 32'hAA22CC44);

      // Same-cycle s1 write / s2 read collision returns old data
      s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = 4'd3;
      s1_byteenable = 4'hF; s1_writedata = 32'hDEADBEEF;
      s2_read = 1'b1; s2_address = 4'd3;
      tick();
      check("rdw_old_a", {a_s2_rdv, a_s2_rdata}, {1'b1, 32'h0});
      s1_write = 1'b0; s1_chipselect = 1'b0;
      tick();
      check("rdw_new_a", {a_s2_rdv, a_s2_rdata}, {1'b1, 32'hDEADBEEF});
      check("rdw_old_b", {b_s2_rdv, b_s2_rdata}, {1'b1, 32'h0});
      s2_read = 1'b0;
      tick();
      check("rdw_new_b", {b_s2_rdv, b_s2_rdata}, {1'b1, 32'hDEADBEEF});
      check("rdw_a_idle", a_s2_rdv, 0);
      tick();

      // Read and write together: write wins, no read issued
      s1_chipselect = 1'b1; s1_read = 1'b1; s1_write = 1'b1; s1_address = 4'd7;
      s1_byteenable = 4'hF; s1_writedata = 32'h5;
      tick();
      check("rw_a_norv", a_s1_rdv, 0);
      s1_read = 1'b0; s1_write = 1'b0; s1_chipselect = 1'b0;
      tick();
      check("rw_rv_none", {a_s1_rdv, b_s1_rdv}, 0);
      s1_chipselect = 1'b1; s1_read = 1'b1;
      tick();
      check("rw_mem7", {a_s1_rdv, a_s1_rdata}, {1'b1, 32'h5});
      s1_read = 1'b0; s1_chipselect = 1'b0;
      tick(); tick();

      // OUTREG=1 stream of 8 reads: pulses start two edges after the first read
      for (int t = 0; t < 10; t++) begin
         s2_read = (t < 8);
         s2_address = AW'(t);
         tick();
         if (t >= 1 && t <= 8)
            check($sformatf("strm_b%0d", t - 1), {b_s2_rdv, b_s2_rdata}, {1'b1, exp8[t-1]});
         else
            check($sformatf("strm_b_idle%0d", t), b_s2_rdv, 0);
      end

      // In-flight read discarded by reset, then reset in the middle of the clear pass
      s2_read = 1'b1; s2_address = 4'd5;
      tick();
      s2_read = 1'b0;
      reset_n = 1'b0;
      #1;
      check("inflight_rst", {b_s2_rdv, b_s2_rdata, a_s1_rdata}, 0);
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      check("midclear_busy", {a_s1_wait, a_init_done}, 2'b10);
      reset_n = 1'b0;
      tick();
      s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = 4'd9;
      s1_byteenable = 4'hF; s1_writedata = 32'hA9;
      reset_n = 1'b1;
      wait_clear(n_cyc, bad);
      check("restart_cycles", n_cyc, 16);
      check("restart_quiet", bad, 0);
      tick();
      s1_write = 1'b0;
      s1_read = 1'b1;
      tick();
      check("held_write", {a_s1_rdv, a_s1_rdata}, {1'b1, 32'hA9});
      s1_address = 4'd5;
      tick();
      check("recleared", {a_s1_rdv, a_s1_rdata}, {1'b1, 32'h0});
      check("noclear_kept", {c_s1_rdv, c_s1_rdata}, {1'b1, 32'hAA22CC44});
      s1_read = 1'b0; s1_chipselect = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
